operand_fetch_stage: RTL and testbench

//  Register-read stage that sits directly upstream of execution_unit.
//  - Accepts decoded instructions over a valid/ready handshake.
//  - Reads rs1/rs2 from the architectural register file and commits writeback.
//  - Presents a registered instruction_t plus operand values to the execute stage.
//  - A 2-entry (main + skid) output buffer keeps in_ready registered and operands fresh during stalls.

---
 rtl/operand_fetch_stage_pkg.sv | 34 +++
 rtl/operand_fetch_stage_register_file.sv | 47 ++++
 rtl/operand_fetch_stage.sv | 127 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, instruction format and the operand refresh helper for the operand fetch stage.
package operand_fetch_stage_pkg;

  localparam int REGISTER_WIDTH        = 32;
  localparam int REG_ADDR_WIDTH        = 5;
  localparam int NUM_REGISTERS_DEFAULT = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REGISTER_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic [6:0]  opcode;
    reg_addr_t   rd;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic [11:0] imm;
  } instruction_t;

  // A buffered operand takes the writeback value when its source register is being written.
  function automatic reg_data_t refresh_operand(input reg_data_t cur,
                                                input reg_addr_t rs,
                                                input logic      hit,
                                                input reg_addr_t wb_rd,
                                                input reg_data_t wb_data);
    reg_data_t res;
    if (hit && (rs == wb_rd)) begin
      res = wb_data;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_register_file.sv
// Architectural register file: two combinational read ports, one write port, x0 reads zero.
module operand_fetch_stage_register_file
  import operand_fetch_stage_pkg::*;
#(
  parameter int NUM_REGISTERS = NUM_REGISTERS_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  reg_data_t wr_data_i,
  input  reg_addr_t rd_addr1_i,
  output reg_data_t rd_data1_o,
  input  reg_addr_t rd_addr2_i,
  output reg_data_t rd_data2_o
);

  reg_data_t regs_q [NUM_REGISTERS];

  // Register storage; x0 is never written and addresses beyond the file are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0) && (int'(wr_addr_i) < NUM_REGISTERS)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read ports.
  always_comb begin
    rd_data1_o = '0;
    rd_data2_o = '0;
    if ((rd_addr1_i != '0) && (int'(rd_addr1_i) < NUM_REGISTERS)) begin
      rd_data1_o = regs_q[rd_addr1_i];
    end else begin
      rd_data1_o = '0;
    end
    if ((rd_addr2_i != '0) && (int'(rd_addr2_i) < NUM_REGISTERS)) begin
      rd_data2_o = regs_q[rd_addr2_i];
    end else begin
      rd_data2_o = '0;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage: accepts decoded instructions, reads operands and presents them to execute
// through a main + skid output buffer whose operands track writebacks while stalled.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int NUM_REGISTERS = NUM_REGISTERS_DEFAULT,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  instruction_t in_instruction,
  input  logic         wb_enable,
  input  reg_addr_t    wb_rd,
  input  reg_data_t    wb_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instruction,
  output reg_data_t    rs1_value,
  output reg_data_t    rs2_value
);

  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  instruction_t main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  reg_data_t    main_rs1_q, main_rs1_d, main_rs2_q, main_rs2_d;
  reg_data_t    skid_rs1_q, skid_rs1_d, skid_rs2_q, skid_rs2_d;

  logic         wb_hit_s, accept_s, transfer_s;
  reg_data_t    rf_rs1_s, rf_rs2_s, acc_rs1_s, acc_rs2_s;
  reg_data_t    main_rs1_ref_s, main_rs2_ref_s, skid_rs1_ref_s, skid_rs2_ref_s;

  operand_fetch_stage_register_file #(
    .NUM_REGISTERS(NUM_REGISTERS)
  ) u_register_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wb_enable),
    .wr_addr_i  (wb_rd),
    .wr_data_i  (wb_data),
    .rd_addr1_i (in_instruction.rs1),
    .rd_data1_o (rf_rs1_s),
    .rd_addr2_i (in_instruction.rs2),
    .rd_data2_o (rf_rs2_s)
  );

  assign wb_hit_s   = wb_enable && (wb_rd != '0);
  assign in_ready   = !skid_valid_q;
  assign accept_s   = in_valid && in_ready;
  assign transfer_s = main_valid_q && out_ready;

  assign acc_rs1_s = ((ENABLE_BYPASS != 0) && wb_hit_s && (wb_rd == in_instruction.rs1)) ? wb_data : rf_rs1_s;
  assign acc_rs2_s = ((ENABLE_BYPASS != 0) && wb_hit_s && (wb_rd == in_instruction.rs2)) ? wb_data : rf_rs2_s;

  assign main_rs1_ref_s = refresh_operand(main_rs1_q, main_instr_q.rs1, main_valid_q && wb_hit_s, wb_rd, wb_data);
  assign main_rs2_ref_s = refresh_operand(main_rs2_q, main_instr_q.rs2, main_valid_q && wb_hit_s, wb_rd, wb_data);
  assign skid_rs1_ref_s = refresh_operand(skid_rs1_q, skid_instr_q.rs1, skid_valid_q && wb_hit_s, wb_rd, wb_data);
  assign skid_rs2_ref_s = refresh_operand(skid_rs2_q, skid_instr_q.rs2, skid_valid_q && wb_hit_s, wb_rd, wb_data);

  // Buffer moves: skid drains into main ahead of any new accept so program order holds.
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_rs1_d   = main_rs1_ref_s;
    main_rs2_d   = main_rs2_ref_s;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_rs1_d   = skid_rs1_ref_s;
    skid_rs2_d   = skid_rs2_ref_s;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || transfer_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_rs1_d   = skid_rs1_ref_s;
        main_rs2_d   = skid_rs2_ref_s;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instruction;
        main_rs1_d   = acc_rs1_s;
        main_rs2_d   = acc_rs2_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instruction;
      skid_rs1_d   = acc_rs1_s;
      skid_rs2_d   = acc_rs2_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_rs1_q   <= '0;
      main_rs2_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_rs1_q   <= '0;
      skid_rs2_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_rs1_q   <= main_rs1_d;
      main_rs2_q   <= main_rs2_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_rs1_q   <= skid_rs1_d;
      skid_rs2_q   <= skid_rs2_d;
    end
  end

  assign out_valid       = main_valid_q;
  assign out_instruction = main_instr_q;
  assign rs1_value       = main_rs1_q;
  assign rs2_value       = main_rs2_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized and directed bench for operand_fetch_stage against a queue-based reference model.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  localparam int BYP = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, wb_enable, flush, out_valid, out_ready;
  instruction_t in_instruction, out_instruction;
  reg_addr_t    wb_rd;
  reg_data_t    wb_data, rs1_value, rs2_value;

  typedef struct packed {
    instruction_t ins;
    reg_data_t    a;
    reg_data_t    b;
  } ent_t;

  ent_t      mq[$];
  reg_data_t mregs [32];
  int        n_checks = 0;
  int        n_pass   = 0;
  instruction_t ia, ib, ic;

  always #5 clk = ~clk;

  operand_fetch_stage #(
    .NUM_REGISTERS(32),
    .ENABLE_BYPASS(BYP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .wb_enable       (wb_enable),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input int rs1, input int rs2, input int rd);
    instruction_t i;
    i        = '0;
    i.opcode = 7'($urandom_range(0, 127));
    i.imm    = 12'($urandom_range(0, 4095));
    i.rs1    = 5'(rs1);
    i.rs2    = 5'(rs2);
    i.rd     = 5'(rd);
    return i;
  endfunction

  function automatic reg_data_t model_read(input reg_addr_t a);
    if (a == 5'd0) return 32'd0;
    if (BYP != 0 && wb_enable && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  // Reference: in-order queue of at most two entries, evaluated at a clock edge from current inputs.
  task automatic model_step();
    bit   acc;
    ent_t e;
    acc = in_valid && (mq.size() < 2);
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (wb_enable && wb_rd != 5'd0) begin
        if (e.ins.rs1 == wb_rd) e.a = wb_data;
        if (e.ins.rs2 == wb_rd) e.b = wb_data;
      end
      mq[i] = e;
    end
    e.ins = in_instruction;
    e.a   = model_read(in_instruction.rs1);
    e.b   = model_read(in_instruction.rs2);
    if (flush) mq.delete();
    else if (acc) mq.push_back(e);
    if (wb_enable && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
  endtask

  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("out_instruction", 64'(out_instruction), 64'(mq[0].ins));
      chk("rs1_value", 64'(rs1_value), 64'(mq[0].a));
      chk("rs2_value", 64'(rs2_value), 64'(mq[0].b));
    end
  endtask

  task automatic drive(input logic v, input instruction_t ins, input logic we, input int wr,
                       input logic [31:0] wd, input logic fl, input logic ordy);
    in_valid       = v;
    in_instruction = ins;
    wb_enable      = we;
    wb_rd          = 5'(wr);
    wb_data        = wd;
    flush          = fl;
    out_ready      = ordy;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 0, 32'd0, 1'b0, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_instruction", 64'(out_instruction), 64'd0);
    chk("reset rs1", 64'(rs1_value), 64'd0);
    chk("reset rs2", 64'(rs2_value), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: first accept, empty register file
    drive(1'b1, mk(1, 2, 3), 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();
    chk("t1 out_valid", 64'(out_valid), 64'd1);
    chk("t1 rs1", 64'(rs1_value), 64'd0);
    chk("t1 rs2", 64'(rs2_value), 64'd0);
    chk("t1 in_ready", 64'(in_ready), 64'd1);

    // 2: writeback then read
    drive(1'b0, '0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 1'b1); cycle();
    drive(1'b1, mk(5, 0, 6), 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();
    chk("t2 rs1", 64'(rs1_value), 64'hDEADBEEF);

    // 3: same-cycle bypass
    drive(1'b1, mk(7, 7, 8), 1'b1, 7, 32'h00001234, 1'b0, 1'b1); cycle();
    chk("t3 rs1", 64'(rs1_value), (BYP != 0) ? 64'h1234 : 64'h0);
    chk("t3 rs2", 64'(rs2_value), (BYP != 0) ? 64'h1234 : 64'h0);

    // 4: x0 write dropped
    drive(1'b0, '0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 1'b1); cycle();
    drive(1'b1, mk(0, 0, 1), 1'b1, 0, 32'hFFFFFFFF, 1'b0, 1'b1); cycle();
    chk("t4 rs1", 64'(rs1_value), 64'd0);
    drive(1'b0, '0, 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();

    // 5: stall with skid, refresh while held, ordered release
    ia = mk(1, 3, 2); ib = mk(3, 4, 5); ic = mk(6, 3, 7);
    drive(1'b1, ia, 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, ib, 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    chk("t5 in_ready low", 64'(in_ready), 64'd0);
    drive(1'b1, ic, 1'b1, 3, 32'h55, 1'b0, 1'b0); cycle();
    chk("t5 held instr", 64'(out_instruction), 64'(ia));
    chk("t5 refresh rs2", 64'(rs2_value), 64'h55);
    drive(1'b1, ic, 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, ic, 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();
    chk("t5 second", 64'(out_instruction), 64'(ib));
    chk("t5 skid refresh rs1", 64'(rs1_value), 64'h55);
    drive(1'b1, ic, 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();
    chk("t5 third", 64'(out_instruction), 64'(ic));
    drive(1'b0, '0, 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();

    // 6: flush with both entries full; accept in the flush cycle is discarded
    drive(1'b1, mk(1, 2, 3), 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, mk(4, 5, 6), 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, mk(9, 9, 9), 1'b1, 9, 32'hA5A5A5A5, 1'b1, 1'b1); cycle();
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, mk(9, 0, 1), 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    chk("t6 wb in flush", 64'(rs1_value), 64'hA5A5A5A5);

    // asynchronous reset mid-stream
    drive(1'b1, mk(5, 5, 2), 1'b0, 0, 32'd0, 1'b0, 1'b0); cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst out_instruction", 64'(out_instruction), 64'd0);
    chk("arst rs1", 64'(rs1_value), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    model_reset();
    drive(1'b0, '0, 1'b0, 0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, mk(5, 5, 2), 1'b0, 0, 32'd0, 1'b0, 1'b1); cycle();
    chk("arst x5 cleared", 64'(rs1_value), 64'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)),
            mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
